// File: rtl/idct2d_seq.sv
// 2D IDCT sequencer: drives the 1D engine over one 8x8 block in the shared RAM.
// In-place row pass (stride 1), then in-place column pass (stride 8).
// Host owns the RAM only while the sequencer is idle.
module idct2d_seq #(
    parameter int unsigned LINES      = 8,
    parameter int unsigned ROW_STRIDE = 1,
    parameter int unsigned COL_STRIDE = 8
) (
    input  logic       clk,
    input  logic       reset_n,
    input  logic       start,
    input  logic [1:0] mode,
    output logic       busy,
    output logic       done,
    output logic       ram_sel,
    input  logic       core_rdy,
    output logic       core_en,
    output logic [5:0] core_rstart,
    output logic [5:0] core_wstart,
    output logic [5:0] core_stride,
    output logic       pass,
    output logic [2:0] line
);

    localparam logic [2:0] LastLine  = 3'(LINES - 1);
    localparam logic [5:0] RowStride = 6'(ROW_STRIDE);
    localparam logic [5:0] ColStride = 6'(COL_STRIDE);

    typedef enum logic [1:0] {StIdle, StIssue, StWait, StDone} state_e;

    state_e     state_q, state_d;
    logic       pass_q, pass_d;
    logic [2:0] line_q, line_d;
    logic       cols_q, cols_d;   // latched mode[1]: column pass requested
    logic       first_q, first_d; // first WAIT cycle, engine rdy not yet dropped
    logic       busy_q, busy_d;
    logic       done_q, done_d;

    // Next-state and pass/line sequencing
    always_comb begin
        state_d = state_q;
        pass_d  = pass_q;
        line_d  = line_q;
        cols_d  = cols_q;
        first_d = 1'b0;
        unique case (state_q)
            StIdle: begin
                if (start) begin
                    if (mode != 2'b00) begin
                        cols_d  = mode[1];
                        pass_d  = ~mode[0];
                        line_d  = 3'd0;
                        state_d = StIssue;
                    end else begin
                        state_d = StDone;
                    end
                end
            end
            StIssue: begin
                if (core_rdy) begin
                    first_d = 1'b1;
                    state_d = StWait;
                end
            end
            StWait: begin
                if (!first_q && core_rdy) begin
                    if (line_q != LastLine) begin
                        line_d  = line_q + 3'd1;
                        state_d = StIssue;
                    end else if (!pass_q && cols_q) begin
                        pass_d  = 1'b1;
                        line_d  = 3'd0;
                        state_d = StIssue;
                    end else begin
                        state_d = StDone;
                    end
                end
            end
            StDone: state_d = StIdle;
            default: state_d = StIdle;
        endcase
        busy_d = (state_d != StIdle);
        done_d = (state_d == StDone);
    end

    // State and registered outputs, synchronous active-low reset
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state_q <= StIdle;
            pass_q  <= 1'b0;
            line_q  <= 3'd0;
            cols_q  <= 1'b0;
            first_q <= 1'b0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            pass_q  <= pass_d;
            line_q  <= line_d;
            cols_q  <= cols_d;
            first_q <= first_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
        end
    end

    // Launch strobe and in-place addresses, held stable for the whole ISSUE cycle.
    // reset_n gating keeps a reset cycle from launching the (also resetting) engine.
    always_comb begin
        core_en     = reset_n && (state_q == StIssue) && core_rdy;
        core_rstart = 6'd0;
        core_stride = 6'd0;
        if (state_q == StIssue) begin
            if (pass_q) begin
                core_rstart = 6'(line_q);
                core_stride = ColStride;
            end else begin
                core_rstart = 6'(line_q) * ColStride;
                core_stride = RowStride;
            end
        end
        core_wstart = core_rstart;
    end

    assign busy    = busy_q;
    assign ram_sel = busy_q;
    assign done    = done_q;
    assign pass    = pass_q;
    assign line    = line_q;

endmodule

// File: doc/idct2d_seq.md
Name: idct2d_seq

Overview:
- Sequences the 1D IDCT engine (`idct1d` instance) over one 8x8 coefficient block held in the shared 64-word RAM.
- Performs an in-place row pass (8 launches, stride 1), then an in-place column pass (8 launches, stride 8).
- Sits between the MPEG2 decode controller (start/done handshake) and the 1D engine's en/rdy/rstart/wstart/stride inputs.
- Also drives the RAM ownership select, so the host port may touch RAM only while the sequencer is idle.

Parameters:
- LINES, 8, launches per pass; also the block edge length.
- ROW_STRIDE, 1, stride used for row-pass launches.
- COL_STRIDE, 8, stride used for column-pass launches; also the row-pass start-address step.

Ports:
- clk  input  1  system clock; all state updates on rising edge.
- reset_n  input  1  synchronous reset, active low.
- start  input  1  request a transform; sampled only in IDLE.
- mode  input  2  latched with start. 01 = rows only, 10 = columns only, 11 = rows then columns, 00 = no-op.
- busy  output  1  high from the cycle after start is accepted until DONE inclusive.
- done  output  1  one-cycle pulse when the transform has completed.
- ram_sel  output  1  1 = engine owns RAM, 0 = host owns RAM; equals busy.
- core_rdy  input  1  engine ready, high while the engine is in its reset state.
- core_en  output  1  engine launch strobe.
- core_rstart  output  6  engine read start address.
- core_wstart  output  6  engine write start address; always equal to core_rstart (in place).
- core_stride  output  6  engine stride.
- pass  output  1  debug: 0 = row pass, 1 = column pass.
- line  output  3  debug: current line index.

Behaviour:
- Reset: synchronous; reset_n low at a rising edge forces state IDLE and clears all registers. Outputs busy, done, ram_sel, core_en, pass and line read 0; core_rstart, core_wstart and core_stride read 0. Reset mid-transform abandons it with no done pulse. The engine shares reset_n, so it also returns idle.
- States: IDLE, ISSUE, WAIT, DONE.
- IDLE:
  - start=1 with mode!=00: latch mode, set pass (0 if mode[0] else 1), set line=0, go to ISSUE.
  - start=1 with mode=00: go directly to DONE.
  - start=0: stay in IDLE.
- ISSUE:
  - core_en=1 combinationally only while core_rdy=1; then go to WAIT next cycle.
  - If core_rdy=0, hold in ISSUE with core_en=0.
  - core_en is never high outside ISSUE.
- Address generation, valid in ISSUE:
  - pass 0: rstart = wstart = line*COL_STRIDE, stride = ROW_STRIDE.
  - pass 1: rstart = wstart = line, stride = COL_STRIDE.
  - Arithmetic is 6-bit unsigned; the maximum value 56 cannot wrap.
- WAIT:
  - Ignore core_rdy in the first WAIT cycle, since the engine deasserts rdy one cycle after launch. From then on, wait for core_rdy=1.
  - On core_rdy=1 with line<LINES-1: line+1, go to ISSUE.
  - On core_rdy=1 with line=LINES-1 and (pass=0 and latched mode[1]=1): set pass=1, line=0, go to ISSUE.
  - On core_rdy=1 otherwise: go to DONE.
- DONE: done=1 for exactly one cycle; go to IDLE.
- start behaviour: start while busy is ignored and not queued. start asserted in the same cycle DONE is left takes effect only if it is still high in IDLE.
- Latency, with the standard engine (21 cycles from launch to rdy):
  - Each launch occupies 22 cycles.
  - With start accepted at cycle 0, the first core_en is at cycle 1, and line k is launched at cycle 1+22k.
  - done occurs at cycle 177 for a single pass and at cycle 353 for both passes.
  - A mode=00 start gives done at cycle 1.
- Outputs are registered except core_en and the address outputs. Those are combinational from state, pass and line, and must be stable for the entire ISSUE cycle.

Test Plan:
- Reset: hold reset_n=0 for 2 cycles with start=1 -> all outputs 0 and no core_en for the entire reset.
- mode=01 with the real engine: core_en pulses at cycles 1, 23, …, 155 with rstart 0, 8, …, 56 and stride 1. A single done pulse at cycle 177. RAM rows match the golden 1D IDCT of each row.
- mode=11 with the real engine: 16 launches. Launches 9–16 have rstart 0..7 and stride 8. done at cycle 353, and busy/ram_sel are high over cycles 1–353. RAM matches the golden 2D approximate IDCT.
- Stalled engine model (core_rdy held low for 5 extra cycles before launch 3): the sequencer holds ISSUE with core_en=0. Launch 3 then issues on the first core_rdy=1 with the correct address. Total done is delayed by exactly 5 cycles.
- mode=00, then start pulsed again while busy on mode=10: the no-op gives done at cycle 1 with no core_en. The second start is ignored, and exactly 8 launches with stride 8 occur.
- reset_n=0 during WAIT of launch 6: IDLE next cycle, no done pulse. A fresh start then runs a full sequence from line 0.
